// File: rtl/ext_bus_arbiter.sv
// rtl/ext_bus_arbiter.sv - two-port round-robin arbiter driving a multiplexed 16-bit external bus
// Bus outputs are registered from the current state, so every phase appears on the pads one cycle after the FSM enters it.
module ext_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [15:0] bus_out,
  input  logic [15:0] bus_in,
  output logic        bus_dir,
  output logic        le_lo,
  output logic        le_hi,
  output logic        OEb,
  output logic        WEb_lo,
  output logic        WEb_hi
);

  typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, ACCESS, RECOVER} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state;
  logic        gnt;
  logic        prio1;
  logic        we_q;
  logic        hi_valid;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] hi_tag;
  logic [1:0]  be_q;
  logic [3:0]  cnt;
  logic        pick1;

  assign pick1 = req1 && (!req0 || prio1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      prio1    <= 1'b0;
      we_q     <= 1'b0;
      hi_valid <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hi_tag   <= '0;
      be_q     <= '0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      bus_out  <= '0;
      bus_dir  <= 1'b1;
      le_lo    <= 1'b0;
      le_hi    <= 1'b0;
      OEb      <= 1'b1;
      WEb_lo   <= 1'b1;
      WEb_hi   <= 1'b1;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      bus_out <= '0;
      bus_dir <= 1'b1;
      le_lo   <= 1'b0;
      le_hi   <= 1'b0;
      OEb     <= 1'b1;
      WEb_lo  <= 1'b1;
      WEb_hi  <= 1'b1;
      case (state)
        IDLE: begin
          // Skip the edge that ends ack so a requester dropping req there is not granted again.
          if ((req0 || req1) && !ack0 && !ack1) begin
            gnt     <= pick1;
            prio1   <= !pick1;
            we_q    <= pick1 ? we1 : we0;
            addr_q  <= pick1 ? addr1 : addr0;
            wdata_q <= pick1 ? wdata1 : wdata0;
            be_q    <= pick1 ? be1 : be0;
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          bus_dir <= 1'b0;
          bus_out <= addr_q[15:0];
          le_lo   <= 1'b1;
          cnt     <= WAIT_LD;
          state   <= (hi_valid && addr_q[31:16] == hi_tag) ? ACCESS : ADDR_HI;
        end
        ADDR_HI: begin
          bus_dir  <= 1'b0;
          bus_out  <= addr_q[31:16];
          le_hi    <= 1'b1;
          hi_tag   <= addr_q[31:16];
          hi_valid <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (we_q) begin
            bus_dir <= 1'b0;
            bus_out <= wdata_q;
            WEb_lo  <= ~be_q[0];
            WEb_hi  <= ~be_q[1];
          end else begin
            OEb <= 1'b0;
          end
          if (cnt == 4'd0) state <= RECOVER;
          else             cnt   <= cnt - 4'd1;
        end
        RECOVER: begin
          // OEb is still low on the pads at this edge, so bus_in holds the read data.
          ack0  <= !gnt;
          ack1  <= gnt;
          if (!we_q) rdata <= bus_in;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ext_bus_arbiter.md
EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning extra strobe cycles per access (range 0-15).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  access request, port 0 (data) and port 1 (fetch).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  32 each  halfword address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 be0, be1  input  2 each  byte enables; bit 0 = low byte, bit 1 = high byte.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  16  read data, shared by both ports.
REQ-011 bus_out  output  16  multiplexed address/data out.
REQ-012 bus_in  input  16  multiplexed data in.
REQ-013 bus_dir  output  1  1 = pads input (tri-state), 0 = pads driving.
REQ-014 le_lo, le_hi  output  1 each  external address latch enables, active-high.
REQ-015 OEb, WEb_lo, WEb_hi  output  1 each  active-low read strobe and byte write strobes.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR_LO, ADDR_HI, ACCESS and RECOVER; all bus-side outputs are registered with no combinational glitches.
REQ-017 IDLE: the block SHALL sample req0/req1 at each edge; on any request it grants one port, captures that port's we/addr/wdata/be into internal registers, and moves to ADDR_LO.
REQ-018 Arbitration SHALL be round-robin: a sole requester wins; on simultaneous requests the port not granted last wins; after reset port 0 has priority.
REQ-019 ADDR_LO (1 cycle): bus_dir=0, bus_out=addr[15:0], le_lo=1.
REQ-020 Next state from ADDR_LO SHALL be ACCESS if hi_valid=1 and addr[31:16] equals the hi_tag register, else ADDR_HI.
REQ-021 ADDR_HI (1 cycle): bus_dir=0, bus_out=addr[31:16], le_hi=1; at exit the block sets hi_tag=addr[31:16] and hi_valid=1.
REQ-022 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter.
REQ-023 ACCESS read: bus_dir=1, OEb=0; rdata SHALL be loaded from bus_in on the edge leaving ACCESS.
REQ-024 ACCESS write: bus_dir=0, bus_out=wdata, WEb_lo=~be[0], WEb_hi=~be[1].
REQ-025 A write with be=00 SHALL still sequence fully, with no strobe asserted.
REQ-026 RECOVER (1 cycle): the granted port's ack SHALL be 1, bus_dir=1, all strobes high, le_* low; next state is IDLE.
REQ-027 Outside the phases above, outputs SHALL idle at bus_dir=1, OEb=WEb_lo=WEb_hi=1, le_lo=le_hi=0, bus_out=0.
REQ-028 Latency: ack SHALL rise 3+WAIT_CYCLES edges after the granting edge when ADDR_HI is skipped, and 4+WAIT_CYCLES edges when it is not.
REQ-029 Handshake: a requester SHALL hold req and its inputs stable until ack and drop req on the edge ending ack.
REQ-030 IDLE re-samples req one edge after RECOVER, so a dropped req is never re-granted.
REQ-031 rdata SHALL hold its value until the next read completes.
REQ-032 req inputs changing during a non-IDLE state SHALL be ignored until IDLE.
REQ-033 Only one ack SHALL be high at any time, and never outside RECOVER.
REQ-034 le_lo, le_hi, OEb and the WEb strobes SHALL never be asserted in the same cycle as each other.
REQ-035 bus_dir SHALL be 1 in every cycle with OEb=0.

Reset
REQ-036 While rst_n=0, all outputs SHALL take idle values immediately, asynchronously: ack0=ack1=0, rdata=0, bus_dir=1, strobes high, le_*=0, bus_out=0.
REQ-037 While rst_n=0, FSM=IDLE, hi_valid=0, hi_tag=0, round-robin pointer=port 0, counter=0.
REQ-038 Reset asserted mid-transfer SHALL abort it with no ack; the requester reissues after reset.

Verification
REQ-039 Single read, WAIT=1: req1 with addr=0x0001_2340, bus_in=0xBEEF -> le_lo with bus_out 0x2340, then le_hi with 0x0001, OEb low 2 cycles, ack1 at edge +5, rdata=0xBEEF.
REQ-040 Repeat read to addr 0x0001_2342 -> ADDR_HI skipped, no le_hi pulse, ack at edge +4.
REQ-041 req0 and req1 raised on the same edge after reset -> port 0 served first, then port 1; on the next simultaneous request port 0 is served.
REQ-042 Write be=10, wdata=0xA55A -> bus_dir=0, bus_out=0xA55A, WEb_hi low and WEb_lo high for WAIT+1 cycles; ack0 once.
REQ-043 rst_n pulsed low during ACCESS -> strobes high and bus_dir=1 in the same cycle, no ack, hi_valid cleared (next access emits le_hi).
REQ-044 WAIT_CYCLES=0 and 15 -> strobe width 1 and 16 cycles; protocol checker confirms REQ-033 to REQ-035 throughout.
